// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encodings, minimum divide ratio and width helper
// for the clk_div_bank clock-enable / divided-clock generator.
package clk_div_pkg;

   // Bank sequencing states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;
   localparam logic [1:0] ST_RELOAD = 2'd3;

   // Smallest divide ratio that still yields a square wave
   localparam int MIN_DIV = 2;

   // Bits needed to index n items, never less than one
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel. Holds the divide ratio (and, when
// CLK_DIV_PHASE_EN is defined, a start phase), runs the period counter and
// registers the enable pulse and square-wave decode.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             reload,
   input  logic             load,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [DIV_W-1:0] cfg_phase,
   output logic             ce_out,
   output logic             clk_out
);

   localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0] D_MIN = DIV_W'(MIN_DIV);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_new;
   logic [DIV_W-1:0] div_m1;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] phase;

   // Ratios below the minimum are clamped rather than rejected
   assign div_new = (cfg_div < D_MIN) ? D_MIN : cfg_div;
   assign div_m1  = div - ONE;

   // Divide ratio register, written by the load strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       div <= DIV_W'(DEF_DIV);
      else if (load) div <= div_new;
   end

`ifdef CLK_DIV_PHASE_EN
   // Start phase register; a phase outside the new period falls back to 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       phase <= '0;
      else if (load) phase <= (cfg_phase >= div_new) ? '0 : cfg_phase;
   end
`else
   logic unused_phase;
   assign phase        = '0;
   assign unused_phase = ^cfg_phase;
`endif

   // Period counter: preset to the phase on reload, wraps at div-1 while running
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         cnt <= '0;
      else if (reload) cnt <= phase;
      else if (run)    cnt <= (cnt >= div_m1) ? '0 : cnt + ONE;
   end

   // Registered decode: pulse on the last count, high for the first half
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_out  <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         ce_out  <= run && (cnt == div_m1);
         clk_out <= run && (cnt < (div >> 1));
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH reconfigurable integer clock dividers sharing one
// relock sequencer. Optional programmable start phase via CLK_DIV_PHASE_EN.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = 8,
   parameter int LOCK_CYCLES = 16,
   parameter int DEF_DIV     = 2,
   localparam int CH_W       = ch_w(NUM_CH)
) (
   input  logic              clk_in1,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);

   localparam int               LC_W     = ch_w(LOCK_CYCLES);
   localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(LOCK_CYCLES - 1);
   localparam logic [LC_W-1:0]  LC_ONE   = LC_W'(1);
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

   logic [1:0]        state;
   logic [LC_W-1:0]   lock_cnt;
   logic              run;
   logic              reload;
   logic              xfer;
   logic              hit;
   logic [NUM_CH-1:0] load;

   // Handshake: a transfer happens on a rising edge where cfg_valid and
   // cfg_ready are both high. cfg_ready depends only on state, never on
   // cfg_valid. A transfer to a channel number outside the bank completes
   // but changes nothing; a transfer to a real channel forces a full resync.
   assign cfg_ready = (state == ST_SETTLE) || (state == ST_LOCKED);
   assign xfer      = cfg_valid && cfg_ready;
   assign hit       = xfer && ({1'b0, cfg_ch} < NUM_CH_L);
   assign run       = (state == ST_SETTLE) || (state == ST_LOCKED);
   assign reload    = (state == ST_RELOAD);
   assign locked    = (state == ST_LOCKED);

   // Sequencer: IDLE -> SETTLE -> LOCKED, any accepted config goes via RELOAD
   always_ff @(posedge clk_in1 or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   state <= ST_SETTLE;
            ST_SETTLE: begin
               if (hit)                       state <= ST_RELOAD;
               else if (lock_cnt == LC_LAST)  state <= ST_LOCKED;
            end
            ST_LOCKED: if (hit) state <= ST_RELOAD;
            default:   state <= ST_SETTLE;
         endcase
      end
   end

   // Lock counter: cleared by reload, counts SETTLE cycles up to the last one
   always_ff @(posedge clk_in1 or posedge reset) begin
      if (reset)                                           lock_cnt <= '0;
      else if (state == ST_RELOAD)                         lock_cnt <= '0;
      else if ((state == ST_SETTLE) && (lock_cnt != LC_LAST)) lock_cnt <= lock_cnt + LC_ONE;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = hit && (cfg_ch == CH_W'(i));

      clk_div_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk       (clk_in1),
         .rst       (reset),
         .run       (run),
         .reload    (reload),
         .load      (load[i]),
         .cfg_div   (cfg_div),
         .cfg_phase (cfg_phase),
         .ce_out    (ce_out[i]),
         .clk_out   (clk_out[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed bench for clk_div_bank with NUM_CH=3,
// LOCK_CYCLES=16, DEF_DIV=2. Phase-offset steps are built only when
// CLK_DIV_PHASE_EN is defined.
module tb_clk_div_bank;

   localparam int NUM_CH = 3;
   localparam int DIV_W  = 8;
   localparam int LOCK   = 16;

   logic              clk_in1 = 1'b0;
   logic              reset;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_phase;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] ce_out;
   logic              locked;

   int n_chk  = 0;
   int n_fail = 0;
   int jl     = 0;
   int model_div [NUM_CH];
   int model_ph  [NUM_CH];

   clk_div_bank #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .LOCK_CYCLES (LOCK),
      .DEF_DIV     (2)
   ) dut (
      .clk_in1   (clk_in1),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .clk_out   (clk_out),
      .ce_out    (ce_out),
      .locked    (locked)
   );

   // Clock
   always #5 clk_in1 = ~clk_in1;

   task automatic tick();
      @(posedge clk_in1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         model_div[c] = 2;
         model_ph[c]  = 0;
      end
   endtask

   // j counts edges since SETTLE entry (j=0 is the entry edge itself). The
   // decode registered at edge j sees counter value (phase + j - 1) mod div.
   task automatic run_window(input int js, input int je);
      logic [NUM_CH-1:0] e_clk;
      logic [NUM_CH-1:0] e_ce;
      int cv;
      for (int j = js; j <= je; j++) begin
         tick();
         for (int c = 0; c < NUM_CH; c++) begin
            if (j == 0) begin
               e_clk[c] = 1'b0;
               e_ce[c]  = 1'b0;
            end else begin
               cv       = (model_ph[c] + j - 1) % model_div[c];
               e_clk[c] = (cv < model_div[c] / 2);
               e_ce[c]  = (cv == model_div[c] - 1);
            end
         end
         chk($sformatf("clk_out j=%0d", j), 32'(clk_out), 32'(e_clk));
         chk($sformatf("ce_out j=%0d", j), 32'(ce_out), 32'(e_ce));
         chk($sformatf("locked j=%0d", j), 32'(locked), 32'(j >= LOCK));
         chk($sformatf("cfg_ready j=%0d", j), 32'(cfg_ready), 32'd1);
         jl = j;
      end
   endtask

   // Present one config word; checks the accept edge, model updated by caller
   task automatic do_cfg(input int ch, input int dv, input int ph);
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = 8'(dv);
      cfg_phase = 8'(ph);
      tick();
      cfg_valid = 1'b0;
      chk("locked at accept", 32'(locked), 32'd0);
      chk("cfg_ready at accept", 32'(cfg_ready), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_phase = '0;
      model_reset();

      // Reset state
      tick();
      tick();
      chk("rst clk_out", 32'(clk_out), 32'd0);
      chk("rst ce_out", 32'(ce_out), 32'd0);
      chk("rst locked", 32'(locked), 32'd0);
      chk("rst cfg_ready", 32'(cfg_ready), 32'd0);

      // Defaults: all D=2, locked at edge 17
      reset = 1'b0;
      run_window(0, LOCK + 2);

      // ch0 -> D=4, other channels realign
      do_cfg(0, 4, 0);
      model_div[0] = 4;
      run_window(0, LOCK + 4);

`ifdef CLK_DIV_PHASE_EN
      // ch1 D=4 P=2 pulses two cycles ahead of ch0
      do_cfg(1, 4, 2);
      model_div[1] = 4;
      model_ph[1]  = 2;
      run_window(0, LOCK + 4);
      // Phase not below the new ratio is stored as 0
      do_cfg(1, 3, 3);
      model_div[1] = 3;
      model_ph[1]  = 0;
      run_window(0, LOCK + 3);
`endif

      // cfg_div=1 clamps to 2
      do_cfg(0, 1, 0);
      model_div[0] = 2;
      run_window(0, LOCK + 2);

      // Out-of-range channel: accepted, nothing changes
      cfg_valid = 1'b1;
      cfg_ch    = 2'd3;
      cfg_div   = 8'd9;
      cfg_phase = 8'd0;
      run_window(jl + 1, jl + 1);
      cfg_valid = 1'b0;
      run_window(jl + 1, jl + 6);

      // Reset mid-SETTLE after a reconfig
      do_cfg(0, 4, 0);
      model_div[0] = 4;
      run_window(0, 5);
      reset = 1'b1;
      #2;
      chk("async rst clk_out", 32'(clk_out), 32'd0);
      chk("async rst ce_out", 32'(ce_out), 32'd0);
      chk("async rst locked", 32'(locked), 32'd0);
      chk("async rst cfg_ready", 32'(cfg_ready), 32'd0);
      tick();
      reset = 1'b0;
      model_reset();
      run_window(0, LOCK + 2);

      // cfg_valid held through RELOAD: second transfer only once ready
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_div   = 8'd4;
      cfg_phase = 8'd0;
      tick();
      chk("hold accept locked", 32'(locked), 32'd0);
      chk("hold accept ready", 32'(cfg_ready), 32'd0);
      tick();
      chk("hold after reload ready", 32'(cfg_ready), 32'd1);
      chk("hold after reload locked", 32'(locked), 32'd0);
      chk("hold after reload ce", 32'(ce_out), 32'd0);
      cfg_div = 8'd3;
      tick();
      cfg_valid = 1'b0;
      chk("hold second accept ready", 32'(cfg_ready), 32'd0);
      chk("hold second accept locked", 32'(locked), 32'd0);
      model_div[0] = 3;
      run_window(0, LOCK + 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
